fetch_seg: RTL and testbench
============================

// Module: fetch_seg
// PURPOSE
//   IF-side consumer of the hazard controller's stall/flush outputs. Owns the PC register and the
//   IF/ID segment register, applies stall_pc/stall_if_id/flush_if_id with fixed priority, and
//   applies the EX-stage redirect. Keeps hazard performance counters for lab measurements.
//   Sits between instruction memory (combinational read) and the ID stage.
// PARAMETERS
//   PC_RESET   32'h0040_0000  PC value loaded on reset (start of the text segment)
//   NOP_INST   32'h0000_0013  instruction word placed in IF/ID on reset/flush (addi x0,x0,0)
//   CNT_W      32             width of each performance counter
// PORTS
//   clk           in   1      clock, all state updates on rising edge
//   rst           in   1      synchronous, active-high reset
//   stall_pc      in   1      hold PC this cycle (load-use)
//   stall_if_id   in   1      hold IF/ID register this cycle (load-use)
//   flush_if_id   in   1      replace IF/ID contents with bubble (taken branch/jump in EX)
//   redirect_ex   in   1      EX resolved a taken branch/jump; load npc_ex into PC
//   npc_ex        in   32     redirect target from EX
//   inst_if       in   32     instruction word read at pc_if (same cycle)
//   cnt_clr       in   1      synchronous clear of all performance counters
//   pc_if         out  32     current fetch address, drives imem
//   pc_id         out  32     PC of instruction in ID
//   pcadd4_id     out  32     pc_id + 4
//   inst_id       out  32     instruction in ID
//   valid_id      out  1      1 = inst_id is a real fetched instruction, 0 = bubble
//   stall_cnt     out  CNT_W  cycles in which a load-use stall was applied
//   flush_cnt     out  CNT_W  cycles in which IF/ID was flushed
//   fetch_cnt     out  CNT_W  instructions accepted into IF/ID (valid_id written 1)
// BEHAVIOUR
//   Reset (rst=1 at edge): pc_if=PC_RESET; pc_id=0; pcadd4_id=0; inst_id=NOP_INST; valid_id=0;
//     all counters 0. rst overrides every other input.
//   PC update, priority high->low:
//     1. redirect_ex=1 : pc_if <= {npc_ex[31:2],2'b00}   (redirect beats stall_pc; the ID-stage
//        instruction causing the load-use stall is wrong-path)
//     2. stall_pc=1    : pc_if holds
//     3. otherwise     : pc_if <= pc_if + 4, 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000)
//   IF/ID update, priority high->low:
//     1. flush_if_id=1 : inst_id<=NOP_INST, valid_id<=0, pc_id<=0, pcadd4_id<=0
//     2. stall_if_id=1 : all IF/ID fields hold
//     3. otherwise     : pc_id<=pc_if, pcadd4_id<=pc_if+4, inst_id<=inst_if, valid_id<=1
//   Latency: instruction at pc_if appears on inst_id one cycle later; a redirect in cycle N makes
//     pc_if=target in N+1 and inst_id=target's instruction in N+2 (N+1 shows the flush bubble).
//   stall_pc and stall_if_id are expected equal; if they differ, each is applied independently.
//   Counters (all wrap modulo 2^CNT_W, no saturation; cnt_clr beats increment in same cycle):
//     stall_cnt += 1 when stall_pc=1 and redirect_ex=0
//     flush_cnt += 1 when flush_if_id=1
//     fetch_cnt += 1 when IF/ID takes case 3
//   All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//   T1 reset: rst=1 two cycles, release -> pc_if=0x0040_0000, inst_id=0x0000_0013, valid_id=0,
//      counters 0; next 3 cycles pc_if=0x...04,0x...08,0x...0C, valid_id=1 from cycle 1.
//   T2 load-use: stall_pc=stall_if_id=1 for 1 cycle at pc_if=0x0040_0010 -> pc_if and IF/ID
//      hold one cycle, then resume at 0x0040_0014; stall_cnt=1, fetch_cnt not incremented.
//   T3 redirect: redirect_ex=1, npc_ex=0x0040_0100, flush_if_id=1 -> next cycle pc_if=0x0040_0100,
//      valid_id=0, inst_id=NOP; following cycle pc_id=0x0040_0100, valid_id=1; flush_cnt=1.
//   T4 simultaneous: redirect_ex=flush_if_id=stall_pc=stall_if_id=1, npc_ex=0x0040_0203 ->
//      pc_if=0x0040_0200, IF/ID flushed, stall_cnt unchanged, flush_cnt +1.
//   T5 wrap/counters: force pc_if to 0xFFFF_FFFC via redirect -> next pc_if=0x0000_0000; with
//      CNT_W=4 drive 17 stalls -> stall_cnt=1; cnt_clr with stall_pc=1 -> stall_cnt=0.
//   T6 reset mid-stall: rst=1 while stall_pc=1 and flush_if_id=1 -> reset values as T1.

Source files
------------

// File: rtl/fetch_seg_if.sv
// Handshake bundle between the hazard controller / EX stage / imem and the IF-side fetch segment.
interface fetch_seg_if #(
   parameter int CNT_W = 32
);
   logic             stall_pc;
   logic             stall_if_id;
   logic             flush_if_id;
   logic             redirect_ex;
   logic [31:0]      npc_ex;
   logic [31:0]      inst_if;
   logic             cnt_clr;
   logic [31:0]      pc_if;
   logic [31:0]      pc_id;
   logic [31:0]      pcadd4_id;
   logic [31:0]      inst_id;
   logic             valid_id;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] fetch_cnt;

   modport master (
      output stall_pc, stall_if_id, flush_if_id, redirect_ex, npc_ex, inst_if, cnt_clr,
      input  pc_if, pc_id, pcadd4_id, inst_id, valid_id, stall_cnt, flush_cnt, fetch_cnt
   );

   modport slave (
      input  stall_pc, stall_if_id, flush_if_id, redirect_ex, npc_ex, inst_if, cnt_clr,
      output pc_if, pc_id, pcadd4_id, inst_id, valid_id, stall_cnt, flush_cnt, fetch_cnt
   );
endinterface

// File: rtl/fetch_seg.sv
// IF stage: PC register, IF/ID segment register with stall/flush/redirect priority,
// and wrapping hazard performance counters.
module fetch_seg #(
   parameter logic [31:0] PC_RESET = 32'h0040_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013,
   parameter int          CNT_W    = 32
) (
   input  logic       clk,
   input  logic       rst,
   fetch_seg_if.slave bus
);

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      pc_id_q, pc_id_d;
   logic [31:0]      pcadd4_id_q, pcadd4_id_d;
   logic [31:0]      inst_id_q, inst_id_d;
   logic             valid_id_q, valid_id_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

   // Next-state for PC, IF/ID fields and counters.
   always_comb begin
      pc_d        = pc_q;
      pc_id_d     = pc_id_q;
      pcadd4_id_d = pcadd4_id_q;
      inst_id_d   = inst_id_q;
      valid_id_d  = valid_id_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      fetch_cnt_d = fetch_cnt_q;

      // Redirect wins over stall: the stalling ID instruction is on the wrong path.
      if (bus.redirect_ex) begin
         pc_d = bus.npc_ex & 32'hFFFF_FFFC;
      end else if (bus.stall_pc) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_q + 32'd4;
      end

      if (bus.flush_if_id) begin
         pc_id_d     = 32'd0;
         pcadd4_id_d = 32'd0;
         inst_id_d   = NOP_INST;
         valid_id_d  = 1'b0;
      end else if (bus.stall_if_id) begin
         pc_id_d     = pc_id_q;
         pcadd4_id_d = pcadd4_id_q;
         inst_id_d   = inst_id_q;
         valid_id_d  = valid_id_q;
      end else begin
         pc_id_d     = pc_q;
         pcadd4_id_d = pc_q + 32'd4;
         inst_id_d   = bus.inst_if;
         valid_id_d  = 1'b1;
      end

      if (bus.cnt_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
         fetch_cnt_d = '0;
      end else begin
         if (bus.stall_pc && !bus.redirect_ex) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end else begin
            stall_cnt_d = stall_cnt_q;
         end
         if (bus.flush_if_id) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end else begin
            flush_cnt_d = flush_cnt_q;
         end
         if (!bus.flush_if_id && !bus.stall_if_id) begin
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
         end else begin
            fetch_cnt_d = fetch_cnt_q;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= PC_RESET;
         pc_id_q     <= 32'd0;
         pcadd4_id_q <= 32'd0;
         inst_id_q   <= NOP_INST;
         valid_id_q  <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         fetch_cnt_q <= '0;
      end else begin
         pc_q        <= pc_d;
         pc_id_q     <= pc_id_d;
         pcadd4_id_q <= pcadd4_id_d;
         inst_id_q   <= inst_id_d;
         valid_id_q  <= valid_id_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign bus.pc_if     = pc_q;
   assign bus.pc_id     = pc_id_q;
   assign bus.pcadd4_id = pcadd4_id_q;
   assign bus.inst_id   = inst_id_q;
   assign bus.valid_id  = valid_id_q;
   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
   assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_seg.sv
// Directed plus random stimulus for fetch_seg, checked against a cycle-level reference model.
module tb_fetch_seg;
   localparam int CNT_W = 4;
   localparam logic [31:0] PC_RST = 32'h0040_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   fetch_seg_if #(.CNT_W(CNT_W)) bus ();
   fetch_seg #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Reference model state
   logic [31:0]      m_pc, m_pc_id, m_pc4, m_inst;
   logic             m_valid;
   logic [CNT_W-1:0] m_stall, m_flush, m_fetch;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("pc_if", bus.pc_if, m_pc);
      chk("pc_id", bus.pc_id, m_pc_id);
      chk("pcadd4_id", bus.pcadd4_id, m_pc4);
      chk("inst_id", bus.inst_id, m_inst);
      chk("valid_id", {31'd0, bus.valid_id}, {31'd0, m_valid});
      chk("stall_cnt", {28'd0, bus.stall_cnt}, {28'd0, m_stall});
      chk("flush_cnt", {28'd0, bus.flush_cnt}, {28'd0, m_flush});
      chk("fetch_cnt", {28'd0, bus.fetch_cnt}, {28'd0, m_fetch});
   endtask

   // One clock: drive inputs, advance the model, compare after the edge.
   task automatic cyc(input logic r, input logic sp, input logic sif, input logic fl,
                      input logic rd, input logic [31:0] npc, input logic clr);
      logic [31:0] old_pc;
      @(negedge clk);
      rst             = r;
      bus.stall_pc    = sp;
      bus.stall_if_id = sif;
      bus.flush_if_id = fl;
      bus.redirect_ex = rd;
      bus.npc_ex      = npc;
      bus.cnt_clr     = clr;
      bus.inst_if     = imem(m_pc);
      @(posedge clk);
      #1;
      old_pc = m_pc;
      if (r) begin
         m_pc = PC_RST; m_pc_id = 32'd0; m_pc4 = 32'd0; m_inst = NOP; m_valid = 1'b0;
         m_stall = '0; m_flush = '0; m_fetch = '0;
      end else begin
         if (rd)       m_pc = {npc[31:2], 2'b00};
         else if (!sp) m_pc = old_pc + 32'd4;
         if (fl) begin
            m_pc_id = 32'd0; m_pc4 = 32'd0; m_inst = NOP; m_valid = 1'b0;
         end else if (!sif) begin
            m_pc_id = old_pc; m_pc4 = old_pc + 32'd4; m_inst = imem(old_pc); m_valid = 1'b1;
            m_fetch = m_fetch + 1'b1;
         end
         if (sp && !rd) m_stall = m_stall + 1'b1;
         if (fl)        m_flush = m_flush + 1'b1;
         if (clr) begin
            m_stall = '0; m_flush = '0; m_fetch = '0;
         end
      end
      chk_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
   endtask

   initial begin
      logic sp, fl, rd, sif;
      m_pc = PC_RST;
      rst = 1'b1;
      bus.stall_pc = 1'b0; bus.stall_if_id = 1'b0; bus.flush_if_id = 1'b0;
      bus.redirect_ex = 1'b0; bus.npc_ex = 32'd0; bus.cnt_clr = 1'b0; bus.inst_if = 32'd0;

      // T1 reset
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("t1_pc_reset", bus.pc_if, 32'h0040_0000);
      chk("t1_inst_nop", bus.inst_id, 32'h0000_0013);
      run(3);
      chk("t1_pc_after3", bus.pc_if, 32'h0040_000C);
      chk("t1_valid", {31'd0, bus.valid_id}, 32'd1);

      // T2 load-use stall at 0x0040_0010
      run(1);
      chk("t2_pc_at_stall", bus.pc_if, 32'h0040_0010);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("t2_pc_held", bus.pc_if, 32'h0040_0010);
      chk("t2_fetch_cnt", {28'd0, bus.fetch_cnt}, 32'd4);
      run(1);
      chk("t2_pc_resume", bus.pc_if, 32'h0040_0014);
      chk("t2_stall_cnt", {28'd0, bus.stall_cnt}, 32'd1);

      // T3 redirect with flush
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0100, 1'b0);
      chk("t3_pc_target", bus.pc_if, 32'h0040_0100);
      chk("t3_bubble", {31'd0, bus.valid_id}, 32'd0);
      run(1);
      chk("t3_pc_id", bus.pc_id, 32'h0040_0100);
      chk("t3_flush_cnt", {28'd0, bus.flush_cnt}, 32'd1);

      // T4 everything asserted together, misaligned target
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0203, 1'b0);
      chk("t4_pc_aligned", bus.pc_if, 32'h0040_0200);
      chk("t4_stall_cnt", {28'd0, bus.stall_cnt}, 32'd1);
      chk("t4_flush_cnt", {28'd0, bus.flush_cnt}, 32'd2);

      // T5 PC wrap and counter wrap/clear
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
      run(1);
      chk("t5_pc_wrap", bus.pc_if, 32'h0000_0000);
      chk("t5_pcadd4_wrap", bus.pcadd4_id, 32'h0000_0000);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("t5_stall_wrap", {28'd0, bus.stall_cnt}, 32'd1);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      chk("t5_clr_beats_inc", {28'd0, bus.stall_cnt}, 32'd0);

      // Random traffic, occasionally mismatched stalls and resets
      for (int i = 0; i < 300; i++) begin
         sp  = ($urandom_range(0, 3) == 0);
         sif = ($urandom_range(0, 7) == 0) ? ~sp : sp;
         rd  = ($urandom_range(0, 5) == 0);
         fl  = ($urandom_range(0, 7) == 0) ? ~rd : rd;
         cyc(($urandom_range(0, 49) == 0), sp, sif, fl, rd, $urandom, ($urandom_range(0, 19) == 0));
      end

      // T6 reset during stall + flush
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      chk("t6_pc_reset", bus.pc_if, 32'h0040_0000);
      chk("t6_valid", {31'd0, bus.valid_id}, 32'd0);
      chk("t6_flush_cnt", {28'd0, bus.flush_cnt}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
